kernel_flip_streamer: RTL and testbench

Serializes a SIZE×SIZE kernel array into a one-element-per-handshake stream, emitted in 180°-rotated order: reverse raster, starting at [SIZE-1][SIZE-1] and ending at [0][0]. The block feeds the convolution datapath from a parallel kernel register file. It snapshots the array on `start`, streams it under valid/ready flow control, and flags the final element and completion.

---
 rtl/kernel_flip_streamer.sv | 67 ++++++
 tb/tb_kernel_flip_streamer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/kernel_flip_streamer.sv
// kernel_flip_streamer: snapshots a SIZE x SIZE kernel and streams it in 180-degree rotated order.
// Optional KERNEL_FLIP_RASTER_EN adds a raster port selecting natural raster order per run.
module kernel_flip_streamer #(
  parameter int SIZE  = 5,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] kernel_in [SIZE][SIZE],
`ifdef KERNEL_FLIP_RASTER_EN
  input  logic             raster,
`endif
  output logic             busy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done
);
  localparam int CW = SIZE > 1 ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] MAX = CW'(SIZE - 1);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] kbuf [SIZE][SIZE];
  logic [CW-1:0] row, col, row_nx, col_nx, row_step, col_step;
  logic fwd, start_fwd, load, hs, at_end;
`ifdef KERNEL_FLIP_RASTER_EN
  assign start_fwd = raster;
`else
  assign start_fwd = 1'b0;
`endif
  always_comb begin
    load     = state == IDLE && start;
    hs       = state == STREAM && out_ready;
    at_end   = fwd ? (row == MAX && col == MAX) : (row == '0 && col == '0);
    col_step = fwd ? (col == MAX ? '0 : col + 1'b1) : (col == '0 ? MAX : col - 1'b1);
    row_step = fwd ? (col == MAX ? row + 1'b1 : row) : (col == '0 ? row - 1'b1 : row);
    state_nx = load ? STREAM : (hs && at_end) ? IDLE : state;
    col_nx   = load ? (start_fwd ? '0 : MAX) : (hs && !at_end) ? col_step : col;
    row_nx   = load ? (start_fwd ? '0 : MAX) : (hs && !at_end) ? row_step : row;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      fwd   <= 1'b0;
      done  <= 1'b0;
      kbuf  <= '{default: '0};
    end else begin
      state <= state_nx;
      row   <= row_nx;
      col   <= col_nx;
      done  <= hs && at_end;
      if (load) begin
        fwd  <= start_fwd;
        kbuf <= kernel_in;
      end
    end
  end
  // outputs decode only from registered state, never from out_ready
  assign busy      = state == STREAM;
  assign out_valid = busy;
  assign out_last  = busy && at_end;
  assign out_data  = busy ? kbuf[row][col] : '0;
endmodule

// File: tb/tb_kernel_flip_streamer.sv
// tb_kernel_flip_streamer: table-driven runs with a scoreboard, plus reset-abort and SIZE=1 sequences.
`timescale 1ns/1ps
module tb_kernel_flip_streamer;
  localparam int S = 5, W = 32;
  logic clk = 0, reset = 0, start = 0, out_ready = 0;
  logic [W-1:0] kin [S][S];
  logic busy, out_valid, out_last, done;
  logic [W-1:0] out_data;
  logic s_start = 0, s_ready = 1;
  logic [W-1:0] s_kin [1][1];
  logic s_busy, s_valid, s_last, s_done;
  logic [W-1:0] s_data;
`ifdef KERNEL_FLIP_RASTER_EN
  logic raster = 0;
`endif
  always #5 clk = ~clk;
  kernel_flip_streamer #(.SIZE(S), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .kernel_in(kin),
`ifdef KERNEL_FLIP_RASTER_EN
    .raster(raster),
`endif
    .busy(busy), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .done(done));
  kernel_flip_streamer #(.SIZE(1), .WIDTH(W)) dut1 (
    .clk(clk), .reset(reset), .start(s_start), .kernel_in(s_kin),
`ifdef KERNEL_FLIP_RASTER_EN
    .raster(1'b0),
`endif
    .busy(s_busy), .out_data(s_data), .out_valid(s_valid), .out_ready(s_ready),
    .out_last(s_last), .done(s_done));
  typedef struct {logic [W-1:0] data; logic last;} beat_t;
  typedef struct {int ready_pct; bit disturb; bit fwd; int exp_first; int exp_final; int exp_cycles;} vec_t;
  beat_t sb[$];
  beat_t e;
  vec_t vecs[$];
  int n_chk = 0, n_fail = 0, done_cnt = 0, beats = 0;
  logic stall = 0;
  logic [W-1:0] held, last_seen;
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (stall && out_valid) check("hold_data", out_data, held);
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      beats++;
      last_seen = out_data;
      if (sb.size() == 0) check("unexpected_beat", out_data, 'x);
      else begin
        e = sb.pop_front();
        check("beat_data", out_data, e.data);
        check("beat_last", {31'b0, out_last}, {31'b0, e.last});
      end
    end
    stall = out_valid && !out_ready;
    held  = out_data;
  end
  task automatic fill_kernel();
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++) kin[r][c] = W'(r * S + c);
  endtask
  task automatic run(input vec_t v);
    int t;
    done_cnt = 0;
    fill_kernel();
`ifdef KERNEL_FLIP_RASTER_EN
    raster = v.fwd;
`endif
    for (int i = 0; i < S * S; i++) begin
      e.data = W'(v.fwd ? i : S * S - 1 - i);
      e.last = i == S * S - 1;
      sb.push_back(e);
    end
    start = 1;
    out_ready = 1;
    @(posedge clk); #1;
    start = 0;
    check("first_data", out_data, W'(v.exp_first));
    check("busy_on", {31'b0, busy}, 1);
    t = 0;
    while (!done && t < 400) begin
      out_ready = $urandom_range(99) < v.ready_pct;
      if (v.disturb && t == 8) begin
        for (int r = 0; r < S; r++)
          for (int c = 0; c < S; c++) kin[r][c] = '1;
        start = 1;
      end
      if (v.disturb && t == 9) start = 0;
      @(posedge clk); #1;
      t++;
    end
    check("done_seen", {31'b0, done}, 1);
    if (v.exp_cycles >= 0) check("done_latency", W'(t), W'(v.exp_cycles));
    check("idle_valid", {31'b0, out_valid}, 0);
    check("idle_busy", {31'b0, busy}, 0);
    @(posedge clk); #1;
    check("done_pulse_once", {31'b0, done}, 0);
    check("done_count", W'(done_cnt), 1);
    check("sb_empty", W'(sb.size()), 0);
    check("final_value", last_seen, W'(v.exp_final));
    fill_kernel();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end
  initial begin
    int t;
    vecs.push_back('{100, 0, 0, 24, 0, 25});
    vecs.push_back('{50, 0, 0, 24, 0, -1});
    vecs.push_back('{30, 1, 0, 24, 0, -1});
    vecs.push_back('{100, 1, 0, 24, 0, 25});
`ifdef KERNEL_FLIP_RASTER_EN
    vecs.push_back('{100, 0, 1, 0, 24, 25});
    vecs.push_back('{60, 0, 0, 24, 0, -1});
    vecs.push_back('{40, 0, 1, 0, 24, -1});
`endif
    fill_kernel();
    s_kin[0][0] = 'hA5;
    @(posedge clk); #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_last", {31'b0, out_last}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_data", out_data, 0);
    reset = 1;
    @(posedge clk); #1;
    foreach (vecs[i]) run(vecs[i]);
`ifdef KERNEL_FLIP_RASTER_EN
    raster = 0;
`endif
    // abort a stream with reset after ten handshakes
    done_cnt = 0;
    beats = 0;
    for (int i = 0; i < S * S; i++) begin
      e.data = W'(S * S - 1 - i);
      e.last = i == S * S - 1;
      sb.push_back(e);
    end
    start = 1;
    out_ready = 1;
    @(posedge clk); #1;
    start = 0;
    t = 0;
    while (beats < 10 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("beats_before_reset", W'(beats), 10);
    #2 reset = 0;
    #1;
    sb.delete();
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_valid", {31'b0, out_valid}, 0);
    check("abort_last", {31'b0, out_last}, 0);
    check("abort_data", out_data, 0);
    check("abort_done", {31'b0, done}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    check("abort_no_done", W'(done_cnt), 0);
    run(vecs[0]);
    // SIZE=1: single beat then back-to-back restart in the done cycle
    s_start = 1;
    @(posedge clk); #1;
    s_start = 0;
    check("s1_valid", {31'b0, s_valid}, 1);
    check("s1_data", s_data, 'hA5);
    check("s1_last", {31'b0, s_last}, 1);
    @(posedge clk); #1;
    check("s1_done", {31'b0, s_done}, 1);
    check("s1_idle", {31'b0, s_valid}, 0);
    s_start = 1;
    @(posedge clk); #1;
    s_start = 0;
    check("s1_again_valid", {31'b0, s_valid}, 1);
    check("s1_again_data", s_data, 'hA5);
    check("s1_again_last", {31'b0, s_last}, 1);
    @(posedge clk); #1;
    check("s1_again_done", {31'b0, s_done}, 1);
    @(posedge clk); #1;
    check("s1_done_drop", {31'b0, s_done}, 0);
    check("s1_busy_drop", {31'b0, s_busy}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
